// File: rtl/sp_types_pkg.sv
// rtl/sp_types_pkg.sv - shared scratchpad types for the DRAM store scheduler
package sp_types_pkg;

  localparam int WORD_W            = 32;
  localparam int BITS_PER_ROW      = 64;
  localparam int DRAMSCHED_TIMEOUT = 1024;

  typedef struct packed {
    logic [WORD_W-1:0]       addr;
    logic [BITS_PER_ROW-1:0] data;
  } dramFIFO_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dramsched_state_t;

  // Round-robin successor; 2-bit arithmetic gives the 3 -> 0 wrap.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin priority select
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] rr_ptr,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);

  logic [1:0] cand;

  // Walk from the farthest offset down so the one nearest rr_ptr wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr + 2'(i);
      if (req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dramstore_scheduler.sv
// rtl/dramstore_scheduler.sv - round-robin drain of four DRAM store FIFOs onto one store port
module dramstore_scheduler
  import sp_types_pkg::*;
#(
  parameter int NUM_FIFOS      = 4,
  parameter int TIMEOUT_CYCLES = DRAMSCHED_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    dramFIFO0_empty,
  input  logic                    dramFIFO1_empty,
  input  logic                    dramFIFO2_empty,
  input  logic                    dramFIFO3_empty,
  input  dramFIFO_t               dramFIFO0_rdata,
  input  dramFIFO_t               dramFIFO1_rdata,
  input  dramFIFO_t               dramFIFO2_rdata,
  input  dramFIFO_t               dramFIFO3_rdata,
  input  logic                    sStore_hit,
  output logic                    dramFIFO0_REN,
  output logic                    dramFIFO1_REN,
  output logic                    dramFIFO2_REN,
  output logic                    dramFIFO3_REN,
  output logic                    sStore,
  output logic [WORD_W-1:0]       store_addr,
  output logic [BITS_PER_ROW-1:0] store_data,
  output logic                    store_complete,
  output logic [1:0]              grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

  dramsched_state_t     state, state_nxt;
  logic [1:0]           rr_ptr;
  logic [CW-1:0]        cnt;
  logic [NUM_FIFOS-1:0] req_vec;
  logic [NUM_FIFOS-1:0] ren_vec;
  logic                 gnt_valid;
  logic [1:0]           gnt_idx;
  dramFIFO_t            head;

  assign req_vec = ~{dramFIFO3_empty, dramFIFO2_empty, dramFIFO1_empty, dramFIFO0_empty};

  rr_arbiter4 u_arb (
    .req       (req_vec),
    .rr_ptr    (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    case (gnt_idx)
      2'd0:    head = dramFIFO0_rdata;
      2'd1:    head = dramFIFO1_rdata;
      2'd2:    head = dramFIFO2_rdata;
      default: head = dramFIFO3_rdata;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid)  state_nxt = REQ;
      REQ:     if (sStore_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sStore         = 1'b0;
    store_complete = 1'b0;
    busy           = 1'b0;
    ren_vec        = '0;
    case (state)
      IDLE: if (gnt_valid) ren_vec[gnt_idx] = 1'b1;
      REQ: begin
        sStore = 1'b1;
        busy   = 1'b1;
      end
      DONE: begin
        store_complete = 1'b1;
        busy           = 1'b1;
      end
      default: ;
    endcase
  end

  assign dramFIFO0_REN = ren_vec[0];
  assign dramFIFO1_REN = ren_vec[1];
  assign dramFIFO2_REN = ren_vec[2];
  assign dramFIFO3_REN = ren_vec[3];

  // Popped entry is captured at the pop so the FIFO head may move on freely.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      store_addr  <= '0;
      store_data  <= '0;
      grant_id    <= 2'd0;
      rr_ptr      <= 2'd0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            store_addr <= head.addr;
            store_data <= head.data;
            grant_id   <= gnt_idx;
          end
        end
        REQ: begin
          if (!sStore_hit) begin
            if (cnt == CNT_LIM) timeout_err <= 1'b1;
            else                cnt         <= cnt + 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= rr_next(grant_id);
          cnt    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dramstore_scheduler.sv
// tb/tb_dramstore_scheduler.sv - self-checking bench for dramstore_scheduler
module tb_dramstore_scheduler;
  import sp_types_pkg::*;

  localparam int T  = 16;
  localparam int VW = 10 + WORD_W + BITS_PER_ROW;

  logic CLK = 1'b0;
  logic nRST;
  logic e0, e1, e2, e3;
  dramFIFO_t d0, d1, d2, d3;
  logic sStore_hit;
  logic r0, r1, r2, r3;
  logic sStore, store_complete, busy, timeout_err;
  logic [WORD_W-1:0] store_addr;
  logic [BITS_PER_ROW-1:0] store_data;
  logic [1:0] grant_id;

  dramstore_scheduler #(.NUM_FIFOS(4), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .nRST(nRST),
    .dramFIFO0_empty(e0), .dramFIFO1_empty(e1), .dramFIFO2_empty(e2), .dramFIFO3_empty(e3),
    .dramFIFO0_rdata(d0), .dramFIFO1_rdata(d1), .dramFIFO2_rdata(d2), .dramFIFO3_rdata(d3),
    .sStore_hit(sStore_hit),
    .dramFIFO0_REN(r0), .dramFIFO1_REN(r1), .dramFIFO2_REN(r2), .dramFIFO3_REN(r3),
    .sStore(sStore), .store_addr(store_addr), .store_data(store_data),
    .store_complete(store_complete), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // Transaction-level reference: FIFO contents, the open store, and the pointer.
  dramFIFO_t fq[4][$];
  dramFIFO_t cur;
  int  grants[$];
  int  next_ptr, cur_idx, req_wait, n_complete, pick;
  bit  txn_open, complete_due, to_err, hit_rand;
  logic [VW-1:0] obs_vec, exp_vec;
  logic [3:0] exp_ren;
  int  n_checks = 0;
  int  n_errors = 0;

  function automatic dramFIFO_t rand_entry();
    dramFIFO_t e;
    e.addr = $urandom;
    e.data = {$urandom, $urandom};
    return e;
  endfunction

  task automatic drive_inputs();
    e0 = (fq[0].size() == 0); d0 = (fq[0].size() != 0) ? fq[0][0] : '0;
    e1 = (fq[1].size() == 0); d1 = (fq[1].size() != 0) ? fq[1][0] : '0;
    e2 = (fq[2].size() == 0); d2 = (fq[2].size() != 0) ? fq[2][0] : '0;
    e3 = (fq[3].size() == 0); d3 = (fq[3].size() != 0) ? fq[3][0] : '0;
  endtask

  task automatic model_reset();
    txn_open = 0; complete_due = 0; next_ptr = 0; to_err = 0; req_wait = 0;
    for (int k = 0; k < 4; k++) fq[k].delete();
  endtask

  // One clock: capture expected/observed at the negedge, then advance the model.
  task automatic step();
    bit active;
    @(negedge CLK);
    active = txn_open || complete_due;
    pick = -1;
    exp_ren = 4'b0;
    if (!active) begin
      for (int k = 0; k < 4; k++)
        if (pick < 0 && fq[(next_ptr + k) % 4].size() != 0) pick = (next_ptr + k) % 4;
      if (pick >= 0) exp_ren[pick] = 1'b1;
    end
    exp_vec = {exp_ren, txn_open, complete_due, active, to_err,
               active ? 2'(cur_idx) : 2'b0,
               txn_open ? cur.addr : {WORD_W{1'b0}},
               txn_open ? cur.data : {BITS_PER_ROW{1'b0}}};
    obs_vec = {r3, r2, r1, r0, sStore, store_complete, busy, timeout_err,
               active ? grant_id : 2'b0,
               txn_open ? store_addr : {WORD_W{1'b0}},
               txn_open ? store_data : {BITS_PER_ROW{1'b0}}};
    @(posedge CLK);
    #1;
    if (complete_due) begin
      complete_due = 0;
      n_complete++;
      next_ptr = (cur_idx + 1) % 4;
    end else if (txn_open) begin
      if (sStore_hit) begin
        txn_open = 0;
        complete_due = 1;
      end else begin
        req_wait++;
        if (req_wait >= T) to_err = 1;
      end
    end else if (pick >= 0) begin
      cur = fq[pick].pop_front();
      cur_idx = pick;
      txn_open = 1;
      req_wait = 0;
      grants.push_back(pick);
    end
    if (hit_rand) sStore_hit = ($urandom_range(0, 99) < 40);
    drive_inputs();
  endtask

  task automatic test_reset();
    nRST = 1'b0; sStore_hit = 1'b0; hit_rand = 0; n_complete = 0;
    model_reset();
    drive_inputs();
    #12;
    n_checks++;
    if ({r3, r2, r1, r0, sStore, store_complete, busy, timeout_err, grant_id, store_addr, store_data} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got sStore=%b busy=%b cmpl=%b err=%b gid=%0d addr=%h want all zero",
               sStore, busy, store_complete, timeout_err, grant_id, store_addr);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_idle_hit();
    int c0 = n_complete;
    sStore_hit = 1'b1;
    repeat (6) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL idle_hit got %h want %h", obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (n_complete != c0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL idle_hit_state got busy=%b want 0", busy);
    end
  endtask

  task automatic test_all_fifos();
    int c0 = n_complete;
    grants.delete();
    for (int k = 0; k < 4; k++) begin
      fq[k].push_back(rand_entry());
      fq[k].push_back(rand_entry());
    end
    drive_inputs();
    sStore_hit = 1'b1;
    repeat (30) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL all_fifos got %h want %h", obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (grants.size() != 8 || n_complete - c0 != 8) begin
      n_errors++; $display("FAIL all_fifos_count got %0d grants %0d completes want 8 8", grants.size(), n_complete - c0);
    end
    for (int k = 0; k < grants.size(); k++) begin
      n_checks++;
      if (grants[k] != k % 4) begin
        n_errors++; $display("FAIL all_fifos_order idx %0d got %0d want %0d", k, grants[k], k % 4);
      end
    end
  endtask

  task automatic test_single_fifo2();
    dramFIFO_t e = rand_entry();
    int c0 = n_complete;
    e.addr = 32'h40;
    fq[2].push_back(e);
    drive_inputs();
    sStore_hit = 1'b0;
    repeat (3) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL single_fifo2 got %h want %h", obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (sStore !== 1'b1 || store_addr !== 32'h40 || grant_id !== 2'd2) begin
      n_errors++; $display("FAIL single_fifo2_req got sStore=%b addr=%h gid=%0d want 1 40 2", sStore, store_addr, grant_id);
    end
    sStore_hit = 1'b1;
    repeat (4) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL single_fifo2 got %h want %h", obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (n_complete - c0 != 1) begin
      n_errors++; $display("FAIL single_fifo2_done got %0d completes want 1", n_complete - c0);
    end
  endtask

  task automatic test_rr_skip();
    grants.delete();
    fq[1].push_back(rand_entry());
    fq[3].push_back(rand_entry());
    drive_inputs();
    sStore_hit = 1'b1;
    repeat (10) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL rr_skip got %h want %h", obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (grants.size() != 2 || grants[0] != 3 || grants[1] != 1) begin
      n_errors++; $display("FAIL rr_skip_order got size %0d first %0d want 3 then 1", grants.size(), grants.size() ? grants[0] : -1);
    end
  endtask

  task automatic test_timeout();
    int c0 = n_complete;
    sStore_hit = 1'b0;
    fq[0].push_back(rand_entry());
    drive_inputs();
    repeat (16) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL timeout got %h want %h", obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_errors++; $display("FAIL timeout_early got %b want 0", timeout_err);
    end
    step();
    n_checks++;
    if (timeout_err !== 1'b1 || sStore !== 1'b1) begin
      n_errors++; $display("FAIL timeout_rise got err=%b sStore=%b want 1 1", timeout_err, sStore);
    end
    repeat (5) step();
    sStore_hit = 1'b1;
    repeat (4) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL timeout_hit got %h want %h", obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (timeout_err !== 1'b1 || n_complete - c0 != 1) begin
      n_errors++; $display("FAIL timeout_sticky got err=%b completes=%0d want 1 1", timeout_err, n_complete - c0);
    end
  endtask

  task automatic test_reset_mid_req();
    sStore_hit = 1'b0;
    fq[1].push_back(rand_entry());
    drive_inputs();
    for (int i = 0; i < 10 && !txn_open; i++) step();
    n_checks++;
    if (!txn_open || sStore !== 1'b1 || grant_id !== 2'd1) begin
      n_errors++; $display("FAIL mid_req_setup got sStore=%b gid=%0d want 1 1", sStore, grant_id);
    end
    #1 nRST = 1'b0;
    #1;
    n_checks++;
    if ({sStore, busy, store_complete, grant_id, r3, r2, r1, r0} !== '0) begin
      n_errors++; $display("FAIL mid_req_reset got sStore=%b busy=%b gid=%0d ren=%b%b%b%b want zeros",
                           sStore, busy, grant_id, r3, r2, r1, r0);
    end
    model_reset();
    drive_inputs();
    #1 nRST = 1'b1;
    sStore_hit = 1'b1;
    repeat (5) begin
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL post_reset got %h want %h", obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    hit_rand = 1;
    repeat (400) begin
      if ($urandom_range(0, 99) < 30) begin
        fq[$urandom_range(0, 3)].push_back(rand_entry());
        drive_inputs();
      end
      step();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++; $display("FAIL random got %h want %h", obs_vec, exp_vec);
      end
    end
    hit_rand = 0;
  endtask

  initial begin
    test_reset();
    test_idle_hit();
    test_all_fifos();
    test_single_fifo2();
    test_rr_skip();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dramstore_scheduler.md
Name: dramstore_scheduler

Overview:
- Round-robin scheduler that drains four per-lane DRAM store FIFOs (dramFIFO0..3) into the single scratchpad-to-DRAM store port, one request in flight at a time.
- Pops one entry, holds sStore with addr/data until sStore_hit, then pulses store_complete and advances the round-robin pointer.
- Sits between the dramFIFO bank and the DRAM store interface inside the scratchpad (sp) subsystem.

Parameters:
- NUM_FIFOS, 4: number of requester FIFOs. Fixed at 4; the port list is flat.
- TIMEOUT_CYCLES, 1024: cycles in REQ without sStore_hit before timeout_err is raised.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- dramFIFO0_empty..dramFIFO3_empty  input  1 each  FIFO n empty.
- dramFIFO0_rdata..dramFIFO3_rdata  input  dramFIFO_t each  show-ahead head entry, valid when !empty.
- sStore_hit  input  1  DRAM accepted the current store.
- dramFIFO0_REN..dramFIFO3_REN  output  1 each  single-cycle pop of FIFO n.
- sStore  output  1  store request valid.
- store_addr  output  WORD_W  store address.
- store_data  output  BITS_PER_ROW  store row data.
- store_complete  output  1  single-cycle pulse when a store is accepted.
- grant_id  output  2  index of the FIFO currently being served.
- busy  output  1  high in REQ and DONE.
- timeout_err  output  1  sticky; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, timeout counter 0.
- dramFIFO_t fields: addr [WORD_W-1:0], data [BITS_PER_ROW-1:0].
- States: IDLE, REQ, DONE.
- IDLE:
  - Search FIFOs in order rr_ptr, rr_ptr+1, ... (mod 4) for the first non-empty one, index g.
  - If found, in the same cycle: assert dramFIFOg_REN for exactly 1 cycle, register rdata.addr/.data into store_addr/store_data, grant_id <= g, go to REQ.
  - If none is found, stay in IDLE. No REN is asserted.
- REQ:
  - sStore = 1. store_addr, store_data and grant_id are held stable.
  - Timeout counter increments each cycle.
  - sStore_hit sampled high -> DONE. The hit may arrive in the first REQ cycle; minimum request length is 1 cycle.
  - Counter reaches TIMEOUT_CYCLES-1 without a hit: set timeout_err, stay in REQ (request keeps waiting). Counter saturates.
- DONE:
  - sStore = 0, store_complete = 1 for 1 cycle.
  - rr_ptr <= grant_id+1 (wraps 3 -> 0). Counter cleared. Go to IDLE.
- Minimum throughput: 3 cycles per store (IDLE pop, REQ, DONE).
- Latency: non-empty FIFO in IDLE -> sStore high on the next cycle.
- At most one REN is high in any cycle. REN is never asserted for an empty FIFO.
- sStore_hit while in IDLE or DONE is ignored.
- A FIFO going empty or non-empty while in REQ/DONE has no effect until the next IDLE arbitration.
- Fairness: with all 4 FIFOs non-empty, grants cycle 0,1,2,3,0. A continuously non-empty FIFO waits at most 3 other grants.
- Reset mid-REQ: the popped entry is discarded and outputs return to reset values asynchronously.

Decomposition:
- sp_types_pkg holds:
  - WORD_W, BITS_PER_ROW, dramFIFO_t (addr, data).
  - New enum dramsched_state_t {IDLE, REQ, DONE}.
  - Constant DRAMSCHED_TIMEOUT default.
- Sub-module rr_arbiter4: combinational 4-way round-robin priority select. Inputs: req[3:0], rr_ptr[1:0]. Outputs: gnt_valid, gnt_idx[1:0]. Instantiated once.
- FSM, counter and data registers live in dramstore_scheduler.
- Connects through the existing dramstore_FSM_if sp modport signal names.

Test Plan:
- Only FIFO2 non-empty, addr=0x40 -> dramFIFO2_REN pulses 1 cycle; next cycle sStore=1, store_addr=0x40, grant_id=2. Hit 2 cycles later -> store_complete pulse, then IDLE.
- All four FIFOs non-empty with 2 entries each, immediate hits -> grant order 0,1,2,3,0,1,2,3; 8 store_complete pulses; never two RENs in one cycle.
- rr_ptr=3 after a FIFO2 grant, only FIFO1 and FIFO3 non-empty -> FIFO3 is granted before FIFO1.
- Hold sStore_hit=0 for TIMEOUT_CYCLES (set to 16) -> timeout_err rises after cycle 16 and stays high; later hit -> store_complete pulses, timeout_err remains 1.
- nRST low while in REQ -> sStore, busy, REN and grant_id become 0 immediately. After release with all FIFOs empty -> remains IDLE, no REN.
- sStore_hit pulsed while in IDLE with empty FIFOs -> no store_complete, no state change.
